// File: rtl/i2c_master_wr.sv
// I2C master write engine: START, 7-bit address + W, 0..MAX_BYTES streamed data bytes, STOP.
// Every ACK is checked; a NACK aborts straight to STOP and latches ack_err until the next start.
module i2c_master_wr #(
    parameter int  CLK_DIV   = 125,
    parameter int  MAX_BYTES = 16,
    localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [6:0]       dev_addr,
    input  logic [CNT_W-1:0] byte_count,
    input  logic [7:0]       wr_data,
    output logic             wr_req,
    output logic             busy,
    output logic             done,
    output logic             ack_err,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             sda_in
);

    localparam int               QW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0]    LAST_Q  = QW'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ACK_A,
        DATA,
        ACK_D,
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [QW-1:0]    qcnt_q, qcnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] bytes_left_q, bytes_left_d;
    logic             ack_err_q, ack_err_d;
    logic             sample_q, sample_d;

    logic tick;
    logic bit_end;
    logic sample_pt;

    // The quarter counter only runs outside IDLE, so a frame always starts on a fresh quarter.
    assign tick      = (state_q != IDLE) && (qcnt_q == LAST_Q);
    assign bit_end   = tick && (phase_q == 2'd3);
    assign sample_pt = tick && (phase_q == 2'd2);

    assign busy    = (state_q != IDLE);
    assign ack_err = ack_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            qcnt_q       <= '0;
            phase_q      <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            bytes_left_q <= '0;
            ack_err_q    <= 1'b0;
            sample_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            qcnt_q       <= qcnt_d;
            phase_q      <= phase_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            bytes_left_q <= bytes_left_d;
            ack_err_q    <= ack_err_d;
            sample_q     <= sample_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        qcnt_d       = qcnt_q;
        phase_d      = phase_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        bytes_left_d = bytes_left_q;
        ack_err_d    = ack_err_q;
        sample_d     = sample_q;
        wr_req       = 1'b0;
        done         = 1'b0;

        if (state_q == IDLE) begin
            qcnt_d  = '0;
            phase_d = '0;
        end else if (tick) begin
            qcnt_d  = '0;
            phase_d = phase_q + 2'd1;
        end else begin
            qcnt_d  = qcnt_q + QW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = START;
                    shift_d      = {dev_addr, 1'b0};
                    bitcnt_d     = 3'd7;
                    ack_err_d    = 1'b0;
                    bytes_left_d = (byte_count > MAX_CNT) ? MAX_CNT : byte_count;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = ADDR;
                end
            end

            ADDR, DATA: begin
                if (bit_end) begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q - 3'd1;
                    if (bitcnt_q == 3'd0) begin
                        state_d = (state_q == ADDR) ? ACK_A : ACK_D;
                    end
                end
            end

            // The next byte is fetched in the same cycle the ACK decision is made.
            ACK_A, ACK_D: begin
                if (sample_pt) begin
                    sample_d = sda_in;
                end
                if (bit_end) begin
                    if (sample_q) begin
                        ack_err_d = 1'b1;
                        state_d   = STOP;
                    end else if (bytes_left_q != '0) begin
                        wr_req       = 1'b1;
                        shift_d      = wr_data;
                        bitcnt_d     = 3'd7;
                        bytes_left_d = bytes_left_q - CNT_W'(1);
                        state_d      = DATA;
                    end else begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (bit_end) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            START: begin
                sda_oe = phase_q[1];
            end
            ADDR, DATA: begin
                scl_oe = ~phase_q[1];
                sda_oe = ~shift_q[7];
            end
            ACK_A, ACK_D: begin
                scl_oe = ~phase_q[1];
            end
            STOP: begin
                scl_oe = (phase_q == 2'd0);
                sda_oe = ~phase_q[1];
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_wr.sv
// Self-checking bench for i2c_master_wr: an I2C slave model decodes the bus and a scoreboard
// compares each decoded byte and each completed frame against a transaction-level reference model.
module tb_i2c_master_wr;

    localparam int CLK_DIV   = 4;
    localparam int MAX_BYTES = 4;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);

    typedef struct {
        int wrReqs;
        int ackErr;
        int cycles;
        int nBus;
    } txn_t;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic             start      = 1'b0;
    logic [6:0]       dev_addr   = '0;
    logic [CNT_W-1:0] byte_count = '0;
    logic [7:0]       wr_data    = '0;
    logic             wr_req;
    logic             busy;
    logic             done;
    logic             ack_err;
    logic             scl_oe;
    logic             sda_oe;
    logic             sda_in;
    logic             slaveDrv   = 1'b0;

    int     nCompared   = 0;
    int     nMismatched = 0;
    longint cycleCnt    = 0;
    longint startCycle  = 0;
    int     wrReqCnt    = 0;
    int     busBytes    = 0;
    int     stopSeen    = 0;
    int     nackAt      = -1;
    int     dataIdx     = 0;
    bit     advance     = 1'b0;

    logic [7:0] curData[$];
    logic [7:0] expBytes[$];
    txn_t       expTxn[$];

    bit         sclNow, sdaNow;
    bit         sclPrev = 1'b1;
    bit         sdaPrev = 1'b1;
    bit         inFrame = 1'b0;
    bit         ackPhase = 1'b0;
    int         bitPos = 0;
    int         byteIdx = 0;
    logic [7:0] sh = '0;

    assign sda_in = ~(sda_oe | slaveDrv);

    i2c_master_wr #(
        .CLK_DIV  (CLK_DIV),
        .MAX_BYTES(MAX_BYTES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dev_addr  (dev_addr),
        .byte_count(byte_count),
        .wr_data   (wr_data),
        .wr_req    (wr_req),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cycleCnt);
    endtask

    // Byte source: wr_data is held through the wr_req cycle and advanced one half-cycle later.
    always @(negedge clk) begin
        if (advance) begin
            dataIdx++;
            advance = 1'b0;
        end
        wr_data = (dataIdx < curData.size()) ? curData[dataIdx] : 8'h00;
        if (reset_n && wr_req) begin
            wrReqCnt++;
            advance = 1'b1;
        end
    end

    // Slave model: decodes START/STOP and bytes from the bus and answers each byte's ACK bit.
    always @(negedge clk) begin
        sclNow = ~scl_oe;
        sdaNow = ~(sda_oe | slaveDrv);
        if (!reset_n) begin
            inFrame  = 1'b0;
            ackPhase = 1'b0;
            slaveDrv = 1'b0;
            bitPos   = 0;
        end else if (sclNow && sclPrev && sdaPrev && !sdaNow) begin
            inFrame  = 1'b1;
            ackPhase = 1'b0;
            bitPos   = 0;
            byteIdx  = 0;
        end else if (sclNow && sclPrev && !sdaPrev && sdaNow) begin
            if (inFrame) stopSeen++;
            inFrame  = 1'b0;
            slaveDrv = 1'b0;
        end else if (inFrame && !sclPrev && sclNow && !ackPhase) begin
            sh = {sh[6:0], sdaNow};
            bitPos++;
        end else if (inFrame && sclPrev && !sclNow) begin
            if (ackPhase) begin
                ackPhase = 1'b0;
                slaveDrv = 1'b0;
            end else if (bitPos == 8) begin
                if (expBytes.size() == 0) begin
                    timeoutFail("unexpected_bus_byte");
                end else begin
                    checkOutput("bus_byte", sh, expBytes.pop_front());
                end
                busBytes++;
                slaveDrv = (byteIdx != nackAt);
                byteIdx++;
                bitPos   = 0;
                ackPhase = 1'b1;
            end
        end
        sclPrev = sclNow;
        sdaPrev = sdaNow;
    end

    // Frame-level monitor: every done pulse retires one expected transaction.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (expTxn.size() == 0) begin
                timeoutFail("unexpected_done");
            end else begin
                txn_t t;
                t = expTxn.pop_front();
                checkOutput("wr_req_count", wrReqCnt, t.wrReqs);
                checkOutput("ack_err_at_done", ack_err, t.ackErr);
                checkOutput("done_latency", cycleCnt - startCycle, t.cycles);
                checkOutput("bytes_on_bus", busBytes, t.nBus);
                checkOutput("stop_seen", stopSeen, 1);
                checkOutput("busy_at_done", busy, 1);
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        while ((busy || expTxn.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) timeoutFail("wait_idle");
    endtask

    // Reference model: the slave NACKs bus byte 'nack' (0 = address, -1 = never).
    task automatic applyStimulus(input logic [6:0] addr, input int cnt, input int nack,
                                 input logic [7:0] d0, input logic [7:0] d1);
        int   nEff;
        int   sent;
        int   errExp;
        txn_t t;
        waitIdle();
        @(negedge clk);
        curData.delete();
        curData.push_back(d0);
        curData.push_back(d1);
        for (int i = 2; i < MAX_BYTES + 3; i++) curData.push_back(8'($urandom));
        nEff = (cnt > MAX_BYTES) ? MAX_BYTES : cnt;
        if (nack >= 0 && nack <= nEff) begin
            sent   = nack;
            errExp = 1;
        end else begin
            sent   = nEff;
            errExp = 0;
        end
        expBytes.push_back({addr, 1'b0});
        for (int i = 0; i < sent; i++) expBytes.push_back(curData[i]);
        t.wrReqs = sent;
        t.ackErr = errExp;
        t.nBus   = sent + 1;
        t.cycles = (8 + 36 * (1 + sent)) * CLK_DIV;
        expTxn.push_back(t);
        nackAt     = nack;
        dataIdx    = 0;
        advance    = 1'b0;
        wrReqCnt   = 0;
        busBytes   = 0;
        stopSeen   = 0;
        dev_addr   = addr;
        byte_count = CNT_W'(cnt);
        start      = 1'b1;
        startCycle = cycleCnt;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("ack_err_cleared", ack_err, 0);
    endtask

    task automatic startDuringDone();
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            timeoutFail("wait_done");
        end else begin
            start      = 1'b1;
            dev_addr   = 7'h7F;
            byte_count = CNT_W'(1);
            @(posedge clk);
            #1;
            checkOutput("start_in_done_ignored", busy, 0);
            start = 1'b0;
        end
    endtask

    task automatic resetMidData();
        int n = 0;
        applyStimulus(7'h22, 3, -1, 8'($urandom), 8'($urandom));
        while (wrReqCnt < 1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            timeoutFail("wait_first_wr_req");
            return;
        end
        repeat (2 * 4 * CLK_DIV + 2) @(negedge clk);
        checkOutput("busy_mid_data", busy, 1);
        checkOutput("scl_low_mid_data", scl_oe, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_scl_oe", scl_oe, 0);
        checkOutput("reset_sda_oe", sda_oe, 0);
        checkOutput("reset_busy", busy, 0);
        expBytes.delete();
        expTxn.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int nEff;
        int nack;
        #1;
        checkOutput("reset_busy_init", busy, 0);
        checkOutput("reset_done_init", done, 0);
        checkOutput("reset_wr_req_init", wr_req, 0);
        checkOutput("reset_ack_err_init", ack_err, 0);
        checkOutput("reset_scl_oe_init", scl_oe, 0);
        checkOutput("reset_sda_oe_init", sda_oe, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(7'h1A, 2, -1, 8'h55, 8'hA3);
        applyStimulus(7'h1A, 0, -1, 8'h00, 8'h00);
        applyStimulus(7'h2D, 3, 2, 8'hC3, 8'h3C);
        applyStimulus(7'h50, 2, 0, 8'h12, 8'h34);

        applyStimulus(7'h41, MAX_BYTES + 3, -1, 8'h81, 8'h7E);
        repeat (50) @(negedge clk);
        start      = 1'b1;
        dev_addr   = 7'h0F;
        byte_count = CNT_W'(1);
        @(negedge clk);
        start = 1'b0;
        waitIdle();

        applyStimulus(7'h11, 1, -1, 8'hF0, 8'h0F);
        startDuringDone();
        waitIdle();

        resetMidData();
        applyStimulus(7'h1A, 2, -1, 8'h55, 8'hA3);

        for (int k = 0; k < 8; k++) begin
            cnt  = int'($urandom_range(0, MAX_BYTES + 3));
            nEff = (cnt > MAX_BYTES) ? MAX_BYTES : cnt;
            nack = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nEff)) : -1;
            applyStimulus(7'($urandom), cnt, nack, 8'($urandom), 8'($urandom));
        end
        waitIdle();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
